fp_mul_pipe: RTL and testbench
==============================

# fp_mul_pipe

Parametrised, pipelined IEEE-754-style floating-point multiplier with valid/ready handshakes, round-to-nearest-even, special-value handling and exception flags. It is the pipelined successor to the team's combinational float16 multiplier and sits in the arithmetic datapath between operand-issue logic and result write-back. With default parameters it operates on binary16. It accepts one operation per cycle with a fixed 3-cycle latency when the output is not stalled.

## Interface
- `EXP_W`, default 5: exponent field width; bias = 2^(EXP_W-1)-1.
- `MAN_W`, default 10: stored fraction width, excluding the hidden bit.
- Word width W = 1+EXP_W+MAN_W (16 with defaults).
- `clk` input, 1 bit: single clock, all logic on rising edge.
- `rst_n` input, 1 bit: synchronous, active-low reset.
- `in_valid` input, 1 bit: operands `a`/`b` are valid.
- `in_ready` output, 1 bit: block accepts operands this cycle.
- `a` input, W bits: multiplicand.
- `b` input, W bits: multiplier.
- `out_valid` output, 1 bit: `result`/`flags` are valid.
- `out_ready` input, 1 bit: consumer takes the result this cycle.
- `result` output, W bits: the product.
- `flags` output, 4 bits: {invalid, overflow, underflow, inexact}, aligned with `result`.

## Operation
- **S1 (unpack/classify):**
  - Split sign, exponent and fraction.
  - Classify each operand as zero, subnormal, normal, inf or NaN.
  - Subnormal inputs are flushed to signed zero; no flag is raised.
  - Sign = sign_a XOR sign_b.
  - Exponent sum = exp_a + exp_b - bias, computed signed at EXP_W+2 bits (never truncated).
- **S2 (multiply):** (MAN_W+1)x(MAN_W+1) unsigned product, 2*MAN_W+2 bits wide.
- **S3 (normalise/round/pack):**
  - If the product MSB is set: shift right by 1 and increment the exponent.
  - Guard = bit below the LSB; sticky = OR of all lower bits.
  - Round to nearest, ties to even. A rounding carry out of the mantissa increments the exponent again.
  - inexact = guard OR sticky.
- **Overflow:** final exponent ≥ 2^EXP_W-1 gives signed infinity; overflow=1 and inexact=1.
- **Underflow:** final exponent ≤ 0 gives signed zero (flush, no subnormal output); underflow=1 and inexact=1.
- **Specials (resolved in S1, carried through the pipeline, override arithmetic):**
  - NaN with any operand, or inf×0: canonical NaN (sign 0, exponent all ones, fraction MSB 1, rest 0); invalid=1.
  - inf×nonzero: signed inf, no flags.
  - zero×finite: signed zero, no flags.

## Timing
- Latency is 3 cycles from the accepting edge (in_valid && in_ready) to out_valid, with `out_ready` held high.
- Throughput is 1 op/cycle.
- Each stage has a valid bit. A stage advances when it is empty or the downstream stage advances. in_ready = !S1_valid || S1 advances.
- Backpressure: while out_valid && !out_ready, S3 holds and `result`/`flags` stay stable. Upstream stages fill, then in_ready falls. No operation is dropped or duplicated.
- Capacity is 3 in-flight ops.
- Simultaneous accept and output in one cycle is legal and keeps full throughput.
- Reset: when `rst_n` is low at a clock edge, all stage valids clear.
  - out_valid=0, result=0, flags=0. in_ready=0 during reset and 1 in the first cycle after reset.
  - Ops in flight at reset are discarded.
- Data registers take new values only on stage advance.

## Structure
- Package `fp_pkg` contains:
  - Class enum {ZERO, SUB, NORM, INF, NAN}.
  - Flag bit indices.
  - Functions for bias, canonical NaN, and signed inf/zero as functions of EXP_W/MAN_W.
- One natural sub-module, `fp_round_pack`: the S3 normalise/round/overflow/underflow logic, combinational and parametrised identically.

## Test plan
- 0x3C00 × 0x3C00 (1.0×1.0) → 0x3C00, flags 0, out_valid exactly 3 cycles after acceptance. 0x3E00 × 0x3E00 (1.5×1.5) → 0x4080. 0xC000 × 0x3C00 → 0xC000.
- Rounding: 0x3C01 × 0x3C01 → 0x3C02, inexact only.
- Overflow/underflow:
  - 0x7BFF × 0x7BFF → 0x7C00, flags 0b0101.
  - 0x0400 × 0x0400 → 0x0000, flags 0b0011.
  - 0x8400 × 0x0400 → 0x8000.
- Specials:
  - 0x7C00 × 0x0000 → 0x7E00, invalid.
  - 0x7E00 × 0x3C00 → 0x7E00, invalid.
  - 0xFC00 × 0x4000 → 0xFC00, no flags.
  - 0x0001 (subnormal) × 0x3C00 → 0x0000.
- Backpressure: hold out_ready=0 and offer 5 back-to-back ops → exactly 3 accepted, then in_ready=0. Release out_ready → results emerge in order, one per cycle, each matching the reference model.
- Reset mid-stream: with 3 ops in flight, pull rst_n low for 1 cycle → out_valid=0, result=0, flags=0, no stale results emerge. Resume with 0x3C00 × 0x4000 → 0x4000 after 3 cycles.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared definitions for the pipelined floating-point multiplier:
// operand classes, flag bit positions and width-generic encoding helpers.
package fp_pkg;

  typedef enum logic [2:0] {ZERO, SUB, NORM, INF, NAN} fp_class_e;

  localparam int FLAG_INVALID   = 3;
  localparam int FLAG_OVERFLOW  = 2;
  localparam int FLAG_UNDERFLOW = 1;
  localparam int FLAG_INEXACT   = 0;

  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  // Encodings are built 64 bits wide; callers keep the low 1+exp_w+man_w bits.
  function automatic logic [63:0] fp_canon_nan(input int exp_w, input int man_w);
    logic [63:0] exp_ones;
    exp_ones = (64'd1 << exp_w) - 64'd1;
    return (exp_ones << man_w) | (64'd1 << (man_w - 1));
  endfunction

  function automatic logic [63:0] fp_signed_inf(input logic sign, input int exp_w, input int man_w);
    logic [63:0] exp_ones;
    exp_ones = (64'd1 << exp_w) - 64'd1;
    return ({63'd0, sign} << (exp_w + man_w)) | (exp_ones << man_w);
  endfunction

  function automatic logic [63:0] fp_signed_zero(input logic sign, input int exp_w, input int man_w);
    return {63'd0, sign} << (exp_w + man_w);
  endfunction

endpackage

// File: rtl/fp_round_pack.sv
// Final multiplier stage: normalise the raw significand product, round to
// nearest-even and pack, saturating to inf or flushing to zero at the range limits.
module fp_round_pack
  import fp_pkg::*;
#(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10,
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic                     sign,
  input  logic signed [EXP_W+1:0]  exp_sum,
  input  logic [2*MAN_W+1:0]       prod,
  output logic [W-1:0]             result,
  output logic [3:0]               flags
);

  localparam int PW = 2 * MAN_W + 2;
  localparam logic [63:0] INF_P64  = fp_signed_inf(1'b0, EXP_W, MAN_W);
  localparam logic [63:0] INF_N64  = fp_signed_inf(1'b1, EXP_W, MAN_W);
  localparam logic [63:0] ZERO_P64 = fp_signed_zero(1'b0, EXP_W, MAN_W);
  localparam logic [63:0] ZERO_N64 = fp_signed_zero(1'b1, EXP_W, MAN_W);
  localparam logic signed [EXP_W+1:0] EXP_MAX = (EXP_W + 2)'((1 << EXP_W) - 1);
  localparam logic signed [EXP_W+1:0] EXP_MIN = (EXP_W + 2)'(0);

  logic [PW-1:0]          norm_s;
  logic [MAN_W:0]         mant_s;
  logic                   guard_s;
  logic                   sticky_s;
  logic                   round_up_s;
  logic [MAN_W+1:0]       mant_rnd_s;
  logic signed [EXP_W+1:0] exp_fin_s;
  logic [MAN_W-1:0]       frac_s;

  // Normalise, round and pack; the exponent picks up one increment per carry.
  always_comb begin
    norm_s     = prod[PW-1] ? prod : {prod[PW-2:0], 1'b0};
    mant_s     = norm_s[PW-1:MAN_W+1];
    guard_s    = norm_s[MAN_W];
    sticky_s   = |norm_s[MAN_W-1:0];
    round_up_s = guard_s & (sticky_s | mant_s[0]);
    mant_rnd_s = {1'b0, mant_s} + {{(MAN_W + 1){1'b0}}, round_up_s};
    exp_fin_s  = exp_sum
               + $signed({{(EXP_W + 1){1'b0}}, prod[PW-1]})
               + $signed({{(EXP_W + 1){1'b0}}, mant_rnd_s[MAN_W+1]});
    frac_s     = mant_rnd_s[MAN_W+1] ? mant_rnd_s[MAN_W:1] : mant_rnd_s[MAN_W-1:0];
    flags      = 4'b0000;
    if (exp_fin_s >= EXP_MAX) begin
      result                = sign ? INF_N64[W-1:0] : INF_P64[W-1:0];
      flags[FLAG_OVERFLOW]  = 1'b1;
      flags[FLAG_INEXACT]   = 1'b1;
    end else if (exp_fin_s <= EXP_MIN) begin
      result                = sign ? ZERO_N64[W-1:0] : ZERO_P64[W-1:0];
      flags[FLAG_UNDERFLOW] = 1'b1;
      flags[FLAG_INEXACT]   = 1'b1;
    end else begin
      result                = {sign, exp_fin_s[EXP_W-1:0], frac_s};
      flags[FLAG_INEXACT]   = guard_s | sticky_s;
    end
  end

endmodule

// File: rtl/fp_mul_pipe.sv
// Three-stage pipelined floating-point multiplier with valid/ready flow control:
// S1 unpack/classify, S2 significand multiply, S3 round/pack into the output register.
module fp_mul_pipe
  import fp_pkg::*;
#(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10,
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic [3:0]   flags
);

  localparam int EW = EXP_W + 2;
  localparam int PW = 2 * MAN_W + 2;
  localparam logic signed [EW-1:0] BIAS = EW'(fp_bias(EXP_W));
  localparam logic [63:0] NAN64    = fp_canon_nan(EXP_W, MAN_W);
  localparam logic [63:0] INF_P64  = fp_signed_inf(1'b0, EXP_W, MAN_W);
  localparam logic [63:0] INF_N64  = fp_signed_inf(1'b1, EXP_W, MAN_W);
  localparam logic [63:0] ZERO_P64 = fp_signed_zero(1'b0, EXP_W, MAN_W);
  localparam logic [63:0] ZERO_N64 = fp_signed_zero(1'b1, EXP_W, MAN_W);

  function automatic fp_class_e classify(input logic [W-1:0] x);
    logic [EXP_W-1:0] e;
    logic [MAN_W-1:0] f;
    e = x[W-2:MAN_W];
    f = x[MAN_W-1:0];
    if (e == {EXP_W{1'b0}})      return (f == {MAN_W{1'b0}}) ? ZERO : SUB;
    else if (e == {EXP_W{1'b1}}) return (f == {MAN_W{1'b0}}) ? INF : NAN;
    else                         return NORM;
  endfunction

  fp_class_e         cls_a_s, cls_b_s;
  logic              zero_a_s, zero_b_s, sign_s;
  logic signed [EW-1:0] exp_sum_s;
  logic              special_s;
  logic [W-1:0]      spec_res_s;
  logic [3:0]        spec_flags_s;
  logic              s1_adv_s, s2_adv_s, s3_adv_s;

  logic              s1_valid, s1_sign, s1_special;
  logic signed [EW-1:0] s1_exp;
  logic [MAN_W:0]    s1_man_a, s1_man_b;
  logic [W-1:0]      s1_spec_res;
  logic [3:0]        s1_spec_flags;
  logic              s2_valid, s2_sign, s2_special;
  logic signed [EW-1:0] s2_exp;
  logic [PW-1:0]     s2_prod;
  logic [W-1:0]      s2_spec_res;
  logic [3:0]        s2_spec_flags;
  logic [W-1:0]      rp_result_s;
  logic [3:0]        rp_flags_s;

  assign s3_adv_s = !out_valid || out_ready;
  assign s2_adv_s = !s2_valid || s3_adv_s;
  assign s1_adv_s = !s1_valid || s2_adv_s;
  assign in_ready = rst_n && s1_adv_s;

  // Classify operands and resolve special values; subnormals count as zero.
  always_comb begin
    cls_a_s      = classify(a);
    cls_b_s      = classify(b);
    zero_a_s     = (cls_a_s == ZERO) || (cls_a_s == SUB);
    zero_b_s     = (cls_b_s == ZERO) || (cls_b_s == SUB);
    sign_s       = a[W-1] ^ b[W-1];
    exp_sum_s    = $signed({2'b00, a[W-2:MAN_W]}) + $signed({2'b00, b[W-2:MAN_W]}) - BIAS;
    special_s    = 1'b1;
    spec_res_s   = ZERO_P64[W-1:0];
    spec_flags_s = 4'b0000;
    if ((cls_a_s == NAN) || (cls_b_s == NAN) ||
        ((cls_a_s == INF) && zero_b_s) || ((cls_b_s == INF) && zero_a_s)) begin
      spec_res_s                 = NAN64[W-1:0];
      spec_flags_s[FLAG_INVALID] = 1'b1;
    end else if ((cls_a_s == INF) || (cls_b_s == INF)) begin
      spec_res_s = sign_s ? INF_N64[W-1:0] : INF_P64[W-1:0];
    end else if (zero_a_s || zero_b_s) begin
      spec_res_s = sign_s ? ZERO_N64[W-1:0] : ZERO_P64[W-1:0];
    end else begin
      special_s = 1'b0;
    end
  end

  // Stage valid bits and the output register, cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      out_valid <= 1'b0;
      result    <= {W{1'b0}};
      flags     <= 4'b0000;
    end else begin
      if (s1_adv_s) s1_valid <= in_valid;
      if (s2_adv_s) s2_valid <= s1_valid;
      if (s3_adv_s) begin
        out_valid <= s2_valid;
        if (s2_valid) begin
          result <= s2_special ? s2_spec_res : rp_result_s;
          flags  <= s2_special ? s2_spec_flags : rp_flags_s;
        end
      end
    end
  end

  // Stage data registers load only when their stage advances with a valid op.
  always_ff @(posedge clk) begin
    if (s1_adv_s && in_valid) begin
      s1_sign       <= sign_s;
      s1_exp        <= exp_sum_s;
      s1_man_a      <= {1'b1, a[MAN_W-1:0]};
      s1_man_b      <= {1'b1, b[MAN_W-1:0]};
      s1_special    <= special_s;
      s1_spec_res   <= spec_res_s;
      s1_spec_flags <= spec_flags_s;
    end
    if (s2_adv_s && s1_valid) begin
      s2_sign       <= s1_sign;
      s2_exp        <= s1_exp;
      s2_prod       <= {{(MAN_W + 1){1'b0}}, s1_man_a} * {{(MAN_W + 1){1'b0}}, s1_man_b};
      s2_special    <= s1_special;
      s2_spec_res   <= s1_spec_res;
      s2_spec_flags <= s1_spec_flags;
    end
  end

  fp_round_pack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_round_pack (
    .sign    (s2_sign),
    .exp_sum (s2_exp),
    .prod    (s2_prod),
    .result  (rp_result_s),
    .flags   (rp_flags_s)
  );

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Bench for fp_mul_pipe (binary16): directed vectors, random streaming with
// random backpressure against a real-arithmetic reference model, stall and reset cases.
module tb_fp_mul_pipe;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, out_valid, out_ready;
  logic [15:0] a, b, result;
  logic [3:0]  flags;
  int          n_vec = 0;
  int          n_err = 0;
  logic [19:0] exp_q[$];

  always #5 clk = ~clk;

  fp_mul_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flags(flags)
  );

  logic [15:0] d_a [11] = '{16'h3C00, 16'h3E00, 16'hC000, 16'h3C01, 16'h7BFF, 16'h0400,
                            16'h8400, 16'h7C00, 16'h7E00, 16'hFC00, 16'h0001};
  logic [15:0] d_b [11] = '{16'h3C00, 16'h3E00, 16'h3C00, 16'h3C01, 16'h7BFF, 16'h0400,
                            16'h0400, 16'h0000, 16'h3C00, 16'h4000, 16'h3C00};
  logic [15:0] d_r [11] = '{16'h3C00, 16'h4080, 16'hC000, 16'h3C02, 16'h7C00, 16'h0000,
                            16'h8000, 16'h7E00, 16'h7E00, 16'hFC00, 16'h0000};
  logic [3:0]  d_f [11] = '{4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0101, 4'b0011,
                            4'b0011, 4'b1000, 4'b1000, 4'b0000, 4'b0000};

  function automatic real pow2(input int k);
    real r = 1.0;
    if (k >= 0) repeat (k) r = r * 2.0;
    else repeat (-k) r = r / 2.0;
    return r;
  endfunction

  // Reference: exact real product, then round-to-nearest-even into binary16.
  function automatic logic [19:0] model(input logic [15:0] x, input logic [15:0] y);
    int  ex, ey, fx, fy, e, ip, be;
    logic s;
    real p, m, scaled, fr;
    bit  nx, ny, ix, iy, zx, zy, up;
    ex = int'(x[14:10]); fx = int'(x[9:0]);
    ey = int'(y[14:10]); fy = int'(y[9:0]);
    s  = x[15] ^ y[15];
    nx = (ex == 31) && (fx != 0); ix = (ex == 31) && (fx == 0); zx = (ex == 0);
    ny = (ey == 31) && (fy != 0); iy = (ey == 31) && (fy == 0); zy = (ey == 0);
    if (nx || ny || (ix && zy) || (iy && zx)) return {16'h7E00, 4'b1000};
    if (ix || iy) return {s, 15'h7C00, 4'b0000};
    if (zx || zy) return {s, 15'h0000, 4'b0000};
    p = ((1024.0 + $itor(fx)) * pow2(ex - 25)) * ((1024.0 + $itor(fy)) * pow2(ey - 25));
    m = p; e = 0;
    while (m >= 2.0) begin m = m / 2.0; e++; end
    while (m < 1.0) begin m = m * 2.0; e--; end
    scaled = m * 1024.0;
    ip = $rtoi(scaled);
    fr = scaled - $itor(ip);
    up = (fr > 0.5) || ((fr == 0.5) && (ip % 2 == 1));
    if (up) ip++;
    if (ip == 2048) begin ip = 1024; e++; end
    be = e + 15;
    if (be >= 31) return {s, 15'h7C00, 4'b0101};
    if (be <= 0)  return {s, 15'h0000, 4'b0011};
    return {s, 5'(be), 10'(ip), 3'b000, (fr != 0.0)};
  endfunction

  function automatic logic [15:0] rand_op();
    logic [15:0] v;
    v = 16'($urandom);
    case ($urandom_range(0, 7))
      0: ;
      1: begin
        v[14:10] = ($urandom_range(0, 1) == 1) ? 5'h1F : 5'h00;
        if ($urandom_range(0, 1) == 1) v[9:0] = 10'h000;
      end
      default: v[14:10] = 5'($urandom_range(5, 25));
    endcase
    return v;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = 16'h0000; b = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if (out_valid !== 1'b0 || result !== 16'h0000 || flags !== 4'b0000 || in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: got v=%b r=%h f=%b rdy=%b expected 0 0000 0000 0",
               out_valid, result, flags, in_ready);
    end
    @(negedge clk); rst_n = 1'b1; #1;
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++; $display("FAIL ready_after_reset: got %b expected 1", in_ready);
    end
  endtask

  task automatic test_directed();
    int cnt;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      a = d_a[i]; b = d_b[i]; in_valid = 1'b1; out_ready = 1'b1;
      #1;
      cnt = 0;
      do begin
        @(posedge clk); #1; in_valid = 1'b0; cnt++;
      end while (!out_valid && cnt < 8);
      n_vec++;
      if (cnt !== 3 || result !== d_r[i] || flags !== d_f[i]) begin
        n_err++;
        $display("FAIL directed_%0d %h*%h: got r=%h f=%b lat=%0d expected r=%h f=%b lat=3",
                 i, d_a[i], d_b[i], result, flags, cnt, d_r[i], d_f[i]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_random(input int n_ops);
    int sent = 0, got = 0, cyc = 0;
    bit pend = 1'b0;
    logic [15:0] ca, cb;
    logic [19:0] e;
    while (got < n_ops && cyc < 20000) begin
      @(negedge clk); cyc++;
      if (!pend && sent < n_ops && $urandom_range(0, 3) != 0) begin
        ca = rand_op(); cb = rand_op(); pend = 1'b1;
      end
      in_valid = pend; a = ca; b = cb;
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (out_valid && out_ready) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL random_spurious: got r=%h with no op outstanding", result);
        end else begin
          e = exp_q.pop_front();
          got++;
          if ({result, flags} !== e) begin
            n_err++;
            $display("FAIL random_%0d: got r=%h f=%b expected r=%h f=%b", got, result, flags,
                     e[19:4], e[3:0]);
          end
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(ca, cb)); sent++; pend = 1'b0;
      end
    end
    n_vec++;
    if (got != n_ops) begin
      n_err++; $display("FAIL random_timeout: got %0d results expected %0d", got, n_ops);
    end
    @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
  endtask

  task automatic test_backpressure();
    logic [15:0] oa [5], ob [5];
    logic [15:0] r0;
    logic [3:0]  f0;
    logic [19:0] e;
    int idx = 0;
    for (int i = 0; i < 5; i++) begin
      oa[i] = 16'($urandom); oa[i][14:10] = 5'($urandom_range(8, 22));
      ob[i] = 16'($urandom); ob[i][14:10] = 5'($urandom_range(8, 22));
    end
    exp_q.delete();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      out_ready = 1'b0; in_valid = 1'b1; a = oa[idx]; b = ob[idx];
      #1;
      if (in_ready) begin exp_q.push_back(model(oa[idx], ob[idx])); idx++; end
    end
    @(negedge clk); a = oa[idx]; b = ob[idx]; #1;
    n_vec++;
    if (idx !== 3 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL bp_fill: got accepted=%0d rdy=%b v=%b expected 3 0 1", idx, in_ready, out_valid);
    end
    r0 = result; f0 = flags;
    @(negedge clk); #1;
    n_vec++;
    if (result !== r0 || flags !== f0 || out_valid !== 1'b1) begin
      n_err++; $display("FAIL bp_stable: got r=%h f=%b expected r=%h f=%b", result, flags, r0, f0);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); in_valid = 1'b0; out_ready = 1'b1; #1;
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 20'h00000;
      n_vec++;
      if (out_valid !== 1'b1 || {result, flags} !== e) begin
        n_err++;
        $display("FAIL bp_drain_%0d: got v=%b r=%h f=%b expected v=1 r=%h f=%b", k, out_valid,
                 result, flags, e[19:4], e[3:0]);
      end
    end
    @(negedge clk); #1;
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL bp_extra: got out_valid=%b expected 0", out_valid);
    end
  endtask

  task automatic test_reset_midstream();
    int cnt;
    int stale = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); out_ready = 1'b0; in_valid = 1'b1; a = 16'h4200; b = 16'h4400;
    end
    @(negedge clk); in_valid = 1'b0; rst_n = 1'b0;
    @(posedge clk); #1;
    n_vec++;
    if (out_valid !== 1'b0 || result !== 16'h0000 || flags !== 4'b0000 || in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL midreset_state: got v=%b r=%h f=%b rdy=%b expected 0 0000 0000 0",
               out_valid, result, flags, in_ready);
    end
    @(negedge clk); rst_n = 1'b1; out_ready = 1'b1;
    repeat (6) begin @(posedge clk); #1; if (out_valid) stale++; end
    n_vec++;
    if (stale != 0) begin
      n_err++; $display("FAIL midreset_stale: got %0d stale results expected 0", stale);
    end
    @(negedge clk); a = 16'h3C00; b = 16'h4000; in_valid = 1'b1; #1;
    cnt = 0;
    do begin
      @(posedge clk); #1; in_valid = 1'b0; cnt++;
    end while (!out_valid && cnt < 8);
    n_vec++;
    if (cnt !== 3 || result !== 16'h4000 || flags !== 4'b0000) begin
      n_err++;
      $display("FAIL midreset_resume: got r=%h f=%b lat=%0d expected r=4000 f=0000 lat=3",
               result, flags, cnt);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random(300);
    test_backpressure();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
